// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared definitions for the byte-serial multi-byte adder controller:
// FSM state encoding, default sizing constants and a byte-select helper.
package multibyte_add_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int NBYTES_DEFAULT  = 4;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int MAX_BYTES       = 8;

  // Pick byte i out of an operand zero-extended to the widest legal size.
  function automatic logic [7:0] byte_of(input logic [8*MAX_BYTES-1:0] v,
                                         input int unsigned i);
    return v[i*8 +: 8];
  endfunction

endpackage

// File: rtl/multibyte_add_ctrl.sv
// Byte-serial multi-byte adder controller. Feeds one byte pair at a time to
// an external 8-bit adder through the add_* handshake, ripples the carry
// between bytes and publishes {cout, sum} with a one-cycle done pulse.
// All outputs are registered; the async reset clears them immediately.
module multibyte_add_ctrl
  import multibyte_add_ctrl_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] opa,
  input  logic [8*NBYTES-1:0] opb,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                add_en,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic                add_ready,
  input  logic [7:0]          add_out,
  input  logic                add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [IW-1:0] nidx;
  logic          carry_reg, carry_next;
  logic [7:0]    tcnt_reg, tcnt_next;
  logic [W-1:0]  opa_reg, opa_next;
  logic [W-1:0]  opb_reg, opb_next;
  logic [W-1:0]  res_reg, res_next;
  logic [W-1:0]  sum_reg, sum_next;
  logic          cout_reg, cout_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          add_en_reg, add_en_next;
  logic [7:0]    add_a_reg, add_a_next;
  logic [7:0]    add_b_reg, add_b_next;
  logic          add_cin_reg, add_cin_next;

  assign nidx = idx_reg + 1'b1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and next-output logic; adder operands are loaded on the edge
  // that enters ISSUE so they are already valid during the ISSUE cycle.
  // The working carry is seeded with cin, so byte 0 and later bytes share it.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    carry_next   = carry_reg;
    tcnt_next    = tcnt_reg;
    opa_next     = opa_reg;
    opb_next     = opb_reg;
    res_next     = res_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    add_en_next  = add_en_reg;
    add_a_next   = add_a_reg;
    add_b_next   = add_b_reg;
    add_cin_next = add_cin_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          opa_next     = opa;
          opb_next     = opb;
          carry_next   = cin;
          idx_next     = '0;
          busy_next    = 1'b1;
          add_en_next  = 1'b1;
          add_a_next   = opa[7:0];
          add_b_next   = opb[7:0];
          add_cin_next = cin;
          state_next   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tcnt_next  = '0;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        if (add_ready) begin
          res_next[idx_reg*8 +: 8] = add_out;
          carry_next  = add_cout;
          add_en_next = 1'b0;
          state_next  = S_GAP;
        end else if (tcnt_reg == TO_LAST) begin
          // Abandon the operation; the published sum/cout stay untouched.
          err_next    = 1'b1;
          busy_next   = 1'b0;
          add_en_next = 1'b0;
          state_next  = S_IDLE;
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end

      S_GAP: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_FIN;
        end else begin
          idx_next     = nidx;
          add_en_next  = 1'b1;
          add_a_next   = byte_of(64'(opa_reg), 32'(nidx));
          add_b_next   = byte_of(64'(opb_reg), 32'(nidx));
          add_cin_next = carry_reg;
          state_next   = S_ISSUE;
        end
      end

      S_FIN: begin
        sum_next   = res_reg;
        cout_next  = carry_reg;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      carry_reg   <= 1'b0;
      tcnt_reg    <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      res_reg     <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      add_en_reg  <= 1'b0;
      add_a_reg   <= '0;
      add_b_reg   <= '0;
      add_cin_reg <= 1'b0;
    end else begin
      idx_reg     <= idx_next;
      carry_reg   <= carry_next;
      tcnt_reg    <= tcnt_next;
      opa_reg     <= opa_next;
      opb_reg     <= opb_next;
      res_reg     <= res_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      add_en_reg  <= add_en_next;
      add_a_reg   <= add_a_next;
      add_b_reg   <= add_b_next;
      add_cin_reg <= add_cin_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign sum     = sum_reg;
  assign cout    = cout_reg;
  assign add_en  = add_en_reg;
  assign add_a   = add_a_reg;
  assign add_b   = add_b_reg;
  assign add_cin = add_cin_reg;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench for multibyte_add_ctrl (NBYTES=4, TIMEOUT=15) with a
// behavioural 8-bit adder whose ready delay is fixed, infinite or random.
module tb_multibyte_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] opa, opb;
  logic        cin;
  logic        busy, done, err;
  logic [31:0] sum;
  logic        cout;
  logic        add_en;
  logic [7:0]  add_a, add_b;
  logic        add_cin;
  logic        add_ready;
  logic [7:0]  add_out;
  logic        add_cout;

  int tests = 0;
  int fails = 0;
  int adder_mode = 0;   // 0: ready after 1 cycle, 1: never ready, 2: random 1..5
  int wcnt;
  int cur_delay;

  logic       prev_en, prev_busy;
  logic [7:0] prev_a, prev_b;
  logic       prev_cin;
  int         gap_cnt;
  int         idx_mon;
  logic       cin_log [0:7];

  always #5 clk = ~clk;

  multibyte_add_ctrl #(.NBYTES(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opa       (opa),
    .opb       (opb),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sum       (sum),
    .cout      (cout),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_ready (add_ready),
    .add_out   (add_out),
    .add_cout  (add_cout)
  );

  // Adder model: ready rises cur_delay edges after add_en, drops when add_en drops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_ready <= 1'b0;
      add_out   <= 8'd0;
      add_cout  <= 1'b0;
      wcnt      <= 0;
      cur_delay <= 1;
    end else if (!add_en) begin
      add_ready <= 1'b0;
      wcnt      <= 0;
      cur_delay <= (adder_mode == 2) ? int'($urandom_range(5, 1)) : 1;
    end else begin
      {add_cout, add_out} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
      if (adder_mode != 1 && wcnt + 1 >= cur_delay) add_ready <= 1'b1;
      wcnt <= wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit spam, input int exp_lat);
    logic [32:0] ref_v;
    int k;
    bit seen;
    ref_v = {1'b0, a} + {1'b0, b} + {32'd0, c};
    @(negedge clk);
    opa = a; opb = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k < 200) begin
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        if (spam && busy) begin
          start = 1'($urandom_range(1, 0));
          opa   = $urandom;
          opb   = $urandom;
          cin   = 1'($urandom_range(1, 0));
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    if (exp_lat > 0) check("latency", 64'(k), 64'(exp_lat));
    check("sum", 64'(sum), 64'(ref_v[31:0]));
    check("cout", 64'(cout), 64'(ref_v[32]));
    check("busy_at_done", 64'(busy), 64'd0);
    check("err_at_done", 64'(err), 64'd0);
    $display("[TB] op a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d cycles=%0d", a, b, c, sum, cout, k);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("sum_held", 64'(sum), 64'(ref_v[31:0]));
  endtask

  initial begin
    int  k;
    bit  seen_err, seen_done;

    rst_n = 1'b1; start = 1'b0; opa = '0; opb = '0; cin = 1'b0;
    prev_en = 1'b0; prev_busy = 1'b0; prev_a = '0; prev_b = '0; prev_cin = 1'b0;
    gap_cnt = 0; idx_mon = 0;
    for (int i = 0; i < 8; i++) cin_log[i] = 1'b0;

    // Protocol monitor running alongside the directed steps
    fork
      forever begin
        @(negedge clk);
        if (done || err) check("done_err_exclusive", 64'(done && err), 64'd0);
        if (add_en && prev_en) begin
          check("add_a_stable", 64'(add_a), 64'(prev_a));
          check("add_b_stable", 64'(add_b), 64'(prev_b));
          check("add_cin_stable", 64'(add_cin), 64'(prev_cin));
        end
        if (busy && add_en && !prev_en && prev_busy) check("gap_one_cycle", 64'(gap_cnt), 64'd1);
        if (add_en && !prev_en) begin
          if (!prev_busy) idx_mon = 0;
          if (idx_mon < 8) cin_log[idx_mon] = add_cin;
          idx_mon++;
        end
        if (add_en) gap_cnt = 0;
        else if (busy) gap_cnt++;
        prev_en = add_en; prev_busy = busy;
        prev_a = add_a; prev_b = add_b; prev_cin = add_cin;
      end
    join_none

    // Reset takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_add_en", 64'(add_en), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add, 1-cycle adder, latency 3*4+2
    adder_mode = 0;
    run_op(32'h0000000C, 32'h00000001, 1'b0, 1'b0, 14);

    // Full carry ripple through every byte
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 14);
    check("carry_cin_b0", 64'(cin_log[0]), 64'd0);
    check("carry_cin_b1", 64'(cin_log[1]), 64'd1);
    check("carry_cin_b2", 64'(cin_log[2]), 64'd1);
    check("carry_cin_b3", 64'(cin_log[3]), 64'd1);

    // Carry into byte 0
    run_op(32'h000000FF, 32'h00000000, 1'b1, 1'b0, 14);

    // Timeout: adder never ready, err 15 WAIT cycles later, sum untouched
    adder_mode = 1;
    @(negedge clk);
    opa = 32'h12345678; opb = 32'h11111111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; seen_err = 1'b0; seen_done = 1'b0;
    while (!seen_err && k < 60) begin
      if (err) seen_err = 1'b1;
      else begin
        if (done) seen_done = 1'b1;
        @(posedge clk); #1;
        k++;
      end
    end
    check("timeout_err_seen", 64'(seen_err), 64'd1);
    check("timeout_latency", 64'(k), 64'd17);
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_add_en", 64'(add_en), 64'd0);
    check("timeout_no_done", 64'(seen_done || done), 64'd0);
    check("timeout_sum_kept", 64'(sum), 64'h100);
    check("timeout_cout_kept", 64'(cout), 64'd0);
    $display("[TB] op a=%08h b=%08h timeout err after %0d cycles", 32'h12345678, 32'h11111111, k);
    @(posedge clk); #1;
    check("err_one_cycle", 64'(err), 64'd0);
    adder_mode = 0;

    // Reset during byte 2 WAIT
    @(negedge clk);
    opa = 32'h01020304; opb = 32'h10203040; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midop_in_wait", 64'(add_en), 64'd1);
    check("midop_byte2", 64'(idx_mon), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_add_en", 64'(add_en), 64'd0);
    check("midrst_add_a", 64'(add_a), 64'd0);
    check("midrst_add_b", 64'(add_b), 64'd0);
    check("midrst_add_cin", 64'(add_cin), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_done_err", 64'({done, err}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 64'({busy, done, err, add_en}), 64'd0);
    end
    $display("[TB] op a=%08h b=%08h abandoned by reset", 32'h01020304, 32'h10203040);
    run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, 14);

    // Random ready delay with start pulses while busy
    adder_mode = 2;
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 0);
    run_op(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1, 0)), 1'b1, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multibyte_add_ctrl.md
MULTIBYTE_ADD_CTRL -- requirements
Module: multibyte_add_ctrl

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for add_ready per byte; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 opa  input  8*NBYTES  operand A; captured on accepted start.
REQ-007 opb  input  8*NBYTES  operand B; captured on accepted start.
REQ-008 cin  input  1  carry into byte 0; captured on accepted start.
REQ-009 busy  output  1  high from the cycle after accepted start until done or err.
REQ-010 done  output  1  one-cycle pulse; sum and cout valid in the same cycle.
REQ-011 err  output  1  one-cycle pulse on adder timeout.
REQ-012 sum  output  8*NBYTES  result; held until the next accepted start.
REQ-013 cout  output  1  carry out of the top byte; held with sum.
REQ-014 add_en  output  1  enable to the 8-bit adder stage.
REQ-015 add_a, add_b  output  8 each  byte operands to the adder.
REQ-016 add_cin  output  1  carry into the adder.
REQ-017 add_ready  input  1  adder result valid.
REQ-018 add_out  input  8  adder sum byte.
REQ-019 add_cout  input  1  adder carry out.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, GAP, FIN; no other reachable states.
REQ-021 IDLE + start=1: capture opa, opb and cin; clear byte index to 0; go to ISSUE; start is ignored in all other states.
REQ-022 ISSUE: drive add_en=1 and add_a/add_b = byte[idx] of the captured operands; drive add_cin = captured cin for idx 0, else the stored carry; clear the timeout counter; go to WAIT.
REQ-023 WAIT: hold add_en=1 with add_a, add_b and add_cin unchanged.
REQ-024 WAIT, add_ready=1: write add_out into sum byte[idx]; store add_cout as the carry; go to GAP.
REQ-025 WAIT: after TIMEOUT consecutive cycles with add_ready=0, pulse err, deassert add_en and busy, go to IDLE; sum and cout are left unchanged.
REQ-026 GAP: add_en=0 for exactly one cycle so the adder clears ready; if idx = NBYTES-1 go to FIN, else increment idx and go to ISSUE.
REQ-027 FIN: load cout from the stored carry; pulse done for one cycle; deassert busy; go to IDLE.
REQ-028 Latency with a 1-cycle adder: start to done = 3*NBYTES+2 cycles.
REQ-029 Every byte after byte 0 uses the carry produced by the previous byte; addition is modulo 2^(8*NBYTES) and the overflow carry appears on cout.
REQ-030 add_en is 0 in IDLE, GAP and FIN.
REQ-031 add_ready outside WAIT is ignored.
REQ-032 done and err are never high in the same cycle.

Reset
REQ-033 Reset asserted drives immediately, without waiting for a clock edge: state=IDLE, idx=0, carry=0, busy=0, done=0, err=0, add_en=0, add_a=0, add_b=0, add_cin=0, sum=0, cout=0.
REQ-034 Reset mid-operation abandons the operation; no done or err pulse follows; the first cycle after release is in IDLE.

Structure
REQ-035 A shared package holds the FSM state encoding and the NBYTES and TIMEOUT default constants.
REQ-036 Single module with no sub-modules; the 8-bit adder stage is instantiated by the parent and connected through the add_* ports.

Verification
REQ-037 Basic add: NBYTES=4, opa=0x0000000C, opb=0x00000001, cin=0, adder model with 1-cycle ready -> sum=0x0000000D, cout=0, done exactly 14 cycles after start.
REQ-038 Carry chain: opa=0xFFFFFFFF, opb=0x00000001, cin=0 -> sum=0x00000000, cout=1; add_cin=1 on bytes 1..3.
REQ-039 Carry in: opa=0x000000FF, opb=0, cin=1 -> sum=0x00000100, cout=0.
REQ-040 Timeout: adder model never raises ready -> err pulse after 15 WAIT cycles, busy=0, sum keeps its previous value, no done pulse.
REQ-041 Reset mid-op: assert rst_n=0 during byte 2 WAIT -> all outputs 0 immediately; a start after release completes correctly.
REQ-042 Handshake: adder model with random ready delay of 1..5 cycles and start pulses sent while busy -> add_a/add_b/add_cin stable while add_en=1, add_en=0 for 1 cycle between bytes, start pulses while busy ignored, results match a reference model.
